// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage defaults, FSM states and IF/ID entry type
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    // addi x0,x0,0 used as the bubble encoding
    localparam logic [31:0] NOP_INSTR_DEFAULT    = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // IF/ID entry as seen by the decode stage
    typedef struct packed {
        logic                    valid;
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] pc_plus4;
        logic [31:0]             instr;
    } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with redirect priority over advance
module pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] pc_o
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // next pc: redirect wins, otherwise sequential step (wraps modulo 2^XLEN)
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // pc state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register; optional FETCH_MISALIGN_TRAP_EN
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter logic [31:0]     NOP_INSTR    = NOP_INSTR_DEFAULT
) (
    input  logic            Clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic [31:0]     if_instr
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            if_misalign
`endif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc;
    logic            load;
    logic            advance;
    logic            misfetch;
    logic            frozen;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] plus4_q, plus4_d;
    logic [31:0]     instr_q, instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            mis_q, mis_d;
`endif

    pc_reg #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk_i            (Clk),
        .rst_ni           (reset),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .advance_i        (advance),
        .pc_o             (pc)
    );

    assign imem_addr = pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    // a misaligned pc turns the load into a trap entry and freezes fetch
    assign frozen   = mis_q;
    assign misfetch = load && (pc[1:0] != 2'b00);
`else
    assign frozen   = 1'b0;
    assign misfetch = 1'b0;
`endif

    assign advance = load && !misfetch;

    // FSM next state and load decision; redirect overrides everything
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (redirect_valid) begin
            state_d = RUN;
        end else begin
            case (state_q)
                BOOT:    state_d = RUN;
                RUN:     load    = (!valid_q || id_ready) && !frozen;
                default: state_d = BOOT;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // IF/ID next entry: redirect flushes to a bubble, load captures the fetched word
    always_comb begin
        valid_d = valid_q;
        if_pc_d = if_pc_q;
        plus4_d = plus4_q;
        instr_d = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        if (redirect_valid) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_d   = 1'b0;
`endif
        end else if (load) begin
            valid_d = 1'b1;
            if_pc_d = pc;
            plus4_d = pc + PC_STEP;
            instr_d = misfetch ? NOP_INSTR : imem_rdata;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_d   = misfetch;
`endif
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            if_pc_q <= '0;
            plus4_q <= '0;
            instr_q <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            if_pc_q <= if_pc_d;
            plus4_q <= plus4_d;
            instr_q <= instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign if_valid    = valid_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = plus4_q;
    assign if_instr    = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign if_misalign = mis_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural model
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        if_misalign;
`endif

    int checks   = 0;
    int failures = 0;

    // behavioural model of the visible state
    logic [31:0] m_pc, m_ifpc, m_plus4, m_instr;
    bit          m_boot, m_valid, m_mis;

    fetch_stage dut (
        .Clk            (Clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instr       (if_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .if_misalign    (if_misalign)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_boot  = 1'b1;
        m_valid = 1'b0;
        m_ifpc  = 32'h0;
        m_plus4 = 32'h0;
        m_instr = NOP;
        m_mis   = 1'b0;
    endtask

    task automatic check_model();
        check("imem_addr", imem_addr, m_pc);
        check("if_valid", 32'(if_valid), 32'(m_valid));
        check("if_pc", if_pc, m_ifpc);
        check("if_pc_plus4", if_pc_plus4, m_plus4);
        check("if_instr", if_instr, m_instr);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("if_misalign", 32'(if_misalign), 32'(m_mis));
`endif
    endtask

    // check current outputs, advance the model by one cycle of the rules, clock the DUT
    task automatic step();
        logic [31:0] n_pc, n_ifpc, n_plus4, n_instr;
        bit          n_boot, n_valid, n_mis;
        check_model();
        n_pc = m_pc; n_ifpc = m_ifpc; n_plus4 = m_plus4; n_instr = m_instr;
        n_boot = m_boot; n_valid = m_valid; n_mis = m_mis;
        if (redirect_valid) begin
            n_pc = redirect_pc; n_valid = 1'b0; n_instr = NOP; n_mis = 1'b0; n_boot = 1'b0;
        end else if (m_boot) begin
            n_boot = 1'b0;
        end else if (!m_mis && (!m_valid || id_ready)) begin
            n_valid = 1'b1;
            n_ifpc  = m_pc;
            n_plus4 = m_pc + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (m_pc % 4 != 0) begin
                n_instr = NOP;
                n_mis   = 1'b1;
            end else begin
                n_instr = mem_word(m_pc);
                n_pc    = m_pc + 32'd4;
            end
`else
            n_instr = mem_word(m_pc);
            n_pc    = m_pc + 32'd4;
`endif
        end
        @(posedge Clk);
        #1;
        m_pc = n_pc; m_ifpc = n_ifpc; m_plus4 = n_plus4; m_instr = n_instr;
        m_boot = n_boot; m_valid = n_valid; m_mis = n_mis;
    endtask

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("rst_valid", 32'(if_valid), 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_plus4", if_pc_plus4, 32'h0);
        check("rst_instr", if_instr, NOP);
        check("rst_addr", imem_addr, 32'h0);

        reset = 1'b1;
        step();
        check("boot_valid", 32'(if_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("seq_pc", if_pc, 32'(4 * i));
            check("seq_instr", if_instr, 32'h1000_0000 + 32'(4 * i));
        end

        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", if_pc, 32'h8);
            check("stall_instr", if_instr, 32'h1000_0008);
            check("stall_addr", imem_addr, 32'hC);
        end
        id_ready = 1'b1;
        step();
        check("unstall_pc", if_pc, 32'hC);

        id_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        check("redir_valid", 32'(if_valid), 32'h0);
        check("redir_instr", if_instr, NOP);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        step();
        check("redir_pc", if_pc, 32'h100);
        check("redir_valid2", 32'(if_valid), 32'h1);

        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        step();
        check("wrap_pc0", if_pc, 32'hFFFF_FFF8);
        step();
        check("wrap_pc1", if_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", if_pc_plus4, 32'h0);
        step();
        check("wrap_pc2", if_pc, 32'h0);

        id_ready = 1'b0;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(if_valid), 32'h0);
        check("arst_pc", if_pc, 32'h0);
        check("arst_plus4", if_pc_plus4, 32'h0);
        check("arst_instr", if_instr, NOP);
        check("arst_addr", imem_addr, 32'h0);
        model_reset();
        @(posedge Clk);
        #1;
        reset    = 1'b1;
        id_ready = 1'b1;
        step();
        check("reboot_valid", 32'(if_valid), 32'h0);
        step();
        check("reboot_pc", if_pc, 32'h0);
        check("reboot_valid2", 32'(if_valid), 32'h1);

`ifdef FETCH_MISALIGN_TRAP_EN
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        check("mis_valid0", 32'(if_valid), 32'h0);
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mis_valid", 32'(if_valid), 32'h1);
            check("mis_flag", 32'(if_misalign), 32'h1);
            check("mis_instr", if_instr, NOP);
            check("mis_addr", imem_addr, 32'h102);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        check("mis_clear", 32'(if_misalign), 32'h0);
        check("mis_clear_valid", 32'(if_valid), 32'h0);
        redirect_valid = 1'b0;
        step();
        check("mis_resume_pc", if_pc, 32'h200);
`endif

        for (int i = 0; i < 400; i++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'hFFFF_FFF8;
                1:       redirect_pc = $urandom;
                default: redirect_pc = $urandom & 32'h0000_FFFC;
            endcase
            step();
        end
        redirect_valid = 1'b0;
        check_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
